// File: rtl/full_adder_pkg.sv
// full_adder_pkg: width limit and reference sum shared by the adder and its users.
`default_nettype none

package full_adder_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  // Returns {cout, s} zero-extended: cout lands at bit 'width', higher bits are zero.
  function automatic logic [MAX_WIDTH:0] ref_sum(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 ci,
    input int unsigned          width
  );
    logic [MAX_WIDTH:0] mask;
    mask = (({{MAX_WIDTH{1'b0}}, 1'b1}) << width) - 1'b1;
    return ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{MAX_WIDTH{1'b0}}, ci};
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit combinational full adder.
`default_nettype none

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with combinational and registered results.
`default_nettype none

module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q
);

  logic [WIDTH:0] c;

  assign c[0] = cin;
  assign cout = c[WIDTH];

  // Carry ripples LSB to MSB through one cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_cell u_cell (
      .a  (a1[i]),
      .b  (a2[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s;
      cout_q <= cout;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_full_adder.sv
// tb_full_adder: randomized and directed checks of full_adder at WIDTH 1, 8 and 16.
`default_nettype none

module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;

  logic        a1_1, a2_1, cin_1, s_1, cout_1, sq_1, coutq_1;
  logic [7:0]  a1_8, a2_8, s_8, sq_8;
  logic        cin_8, cout_8, coutq_8;
  logic [15:0] a1_16, a2_16, s_16, sq_16;
  logic        cin_16, cout_16, coutq_16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (
    .a1(a1_1), .a2(a2_1), .cin(cin_1), .s(s_1), .cout(cout_1),
    .clk(clk), .rst_n(rst_n), .s_q(sq_1), .cout_q(coutq_1)
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .a1(a1_8), .a2(a2_8), .cin(cin_8), .s(s_8), .cout(cout_8),
    .clk(clk), .rst_n(rst_n), .s_q(sq_8), .cout_q(coutq_8)
  );

  full_adder #(.WIDTH(16)) u_w16 (
    .a1(a1_16), .a2(a2_16), .cin(cin_16), .s(s_16), .cout(cout_16),
    .clk(clk), .rst_n(rst_n), .s_q(sq_16), .cout_q(coutq_16)
  );

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Plain integer model: the true sum of three unsigned values.
  function automatic longint unsigned model(input longint unsigned a, input longint unsigned b,
                                            input longint unsigned ci);
    return a + b + ci;
  endfunction

  initial begin
    longint unsigned exp8, exp16, exp_reg16;
    logic [2:0] combo;
    logic [64:0] pkg_val;

    rst_n = 1'b1;
    a1_1 = 0; a2_1 = 0; cin_1 = 0;
    a1_8 = 0; a2_8 = 0; cin_8 = 0;
    a1_16 = 0; a2_16 = 0; cin_16 = 0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("reset_w8_sq", {coutq_8, sq_8}, 0);
    check("reset_w16_sq", {coutq_16, sq_16}, 0);
    check("reset_w1_sq", {coutq_1, sq_1}, 0);
    a1_8 = 8'hAA; a2_8 = 8'h11;
    @(posedge clk); #1;
    check("reset_hold_w8", {coutq_8, sq_8}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive sweep
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      a1_1 = combo[2]; a2_1 = combo[1]; cin_1 = combo[0];
      #5;
      check($sformatf("w1_sweep_%0d", i), {cout_1, s_1}, 65'(model(combo[2], combo[1], combo[0])));
    end

    // WIDTH=8 directed boundaries
    a1_8 = 8'hFF; a2_8 = 8'h01; cin_8 = 0; #1;
    check("w8_ff_01_0", {cout_8, s_8}, {56'd0, 9'h100});
    a1_8 = 8'h7F; a2_8 = 8'h01; cin_8 = 1; #1;
    check("w8_7f_01_1", {cout_8, s_8}, {56'd0, 9'h081});
    a1_8 = 8'hFF; a2_8 = 8'hFF; cin_8 = 1; #1;
    check("w8_ff_ff_1", {cout_8, s_8}, {56'd0, 9'h1FF});
    a1_8 = 8'hFF; a2_8 = 8'h00; cin_8 = 1; #1;
    check("w8_ff_00_1", {cout_8, s_8}, {56'd0, 9'h100});
    a1_8 = 8'h00; a2_8 = 8'h00; cin_8 = 0; #1;
    check("w8_zero", {cout_8, s_8}, 0);

    // Registered path: the value held over the last edge is the previous result
    @(negedge clk);
    exp8 = model(a1_8, a2_8, cin_8);
    check("w8_sq_prev_edge", {coutq_8, sq_8}, 65'(exp8[8:0]));
    a1_8 = 8'hF0; a2_8 = 8'h20; cin_8 = 0;
    @(negedge clk);
    a1_8 = 8'h12; a2_8 = 8'h34; cin_8 = 1;
    #1;
    check("w8_sq_before_edge", {coutq_8, sq_8}, {56'd0, 9'h110});
    @(posedge clk); #1;
    check("w8_sq_after_edge", {coutq_8, sq_8}, {56'd0, 9'h047});

    // Mid-operation asynchronous reset
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("w8_async_clear", {coutq_8, sq_8}, 0);
    check("w8_s_during_reset", {cout_8, s_8}, {56'd0, 9'h047});
    @(posedge clk); #1;
    check("w8_hold_in_reset", {coutq_8, sq_8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("w8_no_capture_yet", {coutq_8, sq_8}, 0);
    @(posedge clk); #1;
    check("w8_restore_after_reset", {coutq_8, sq_8}, {56'd0, 9'h047});

    // WIDTH=16 random vectors; registered outputs lag by one cycle
    exp_reg16 = model(a1_16, a2_16, cin_16);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("w16_reg", {coutq_16, sq_16}, 65'(exp_reg16[16:0]));
      a1_16  = 16'($urandom());
      a2_16  = 16'($urandom());
      cin_16 = 1'($urandom());
      if (i % 10 == 0) a1_16 = 16'hFFFF;
      #1;
      exp16 = model(a1_16, a2_16, cin_16);
      check("w16_comb", {cout_16, s_16}, 65'(exp16[16:0]));
      if (i % 100 == 0) begin
        pkg_val = full_adder_pkg::ref_sum({48'd0, a1_16}, {48'd0, a2_16}, cin_16, 16);
        check("pkg_ref_sum", pkg_val, 65'(exp16[16:0]));
      end
      exp_reg16 = exp16;
    end
    @(negedge clk);
    check("w16_reg_last", {coutq_16, sq_16}, 65'(exp_reg16[16:0]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
